if_prefetch_queue: RTL
======================

// Module: if_prefetch_queue
// PURPOSE
//  Parametrised fetch-stage successor: decouples the inst SRAM from ID through a DEPTH-entry prefetch queue.
//  Issues sequential PC requests, buffers {pc,inst}, and hands instructions to ID on a valid/allowin handshake.
//  Handles taken-branch redirects and preserves the MIPS delay slot. Sits between inst SRAM and id_stage.
// PARAMETERS
//  DEPTH     4             queue entries; power of two, >=2
//  PC_W      32            PC width
//  INST_W    32            instruction width
//  RESET_PC  32'hbfc00000  first fetch address after reset
// PORTS
//  clk              in   1             clock
//  resetn           in   1             asynchronous active-low reset
//  br_taken         in   1             taken branch/jump in ID, single-cycle pulse
//  br_pc            in   PC_W          PC of that branch
//  br_target        in   PC_W          redirect target
//  ds_allowin       in   1             ID accepts this cycle
//  fs_to_ds_valid   out  1             queue head valid
//  fs_to_ds_bus     out  PC_W+INST_W   {inst, pc} of head
//  inst_sram_en     out  1             request strobe
//  inst_sram_wen    out  4             always 4'h0
//  inst_sram_addr   out  PC_W          request address
//  inst_sram_wdata  out  32            always 0
//  inst_sram_rdata  in   INST_W        data for previous cycle's request
//  ifq_count        out  $clog2(DEPTH)+1  valid entries
// BEHAVIOUR
//  Reset (async): count=0, fs_to_ds_valid=0, fetch_pc=RESET_PC, in-flight flag=0, state=RUN, inst_sram_en=0.
//  SRAM latency is 1: request in cycle t, inst_sram_rdata valid in t+1. At most one request in flight.
//  Issue rule: inst_sram_en=1 iff count + inflight - pop < DEPTH. pop = fs_to_ds_valid & ds_allowin.
//  Each issue records req_pc and sets inflight. The response is pushed at the tail next cycle unless it was killed.
//  fetch_pc += 4 per issue; PC arithmetic wraps modulo 2^PC_W.
//  Head output is registered from the FIFO. Push to an empty queue is visible to ID one cycle after the response.
//  Push and pop in the same cycle with count==DEPTH is legal; count is unchanged.
//  Delay slot DS = br_pc+4. On br_taken:
//   - DS in queue, or popped this cycle: keep DS, drop all younger entries and kill any in-flight response.
//     fetch_pc<=br_target, state RUN.
//   - DS in flight: clear queue (except an entry popped this cycle) and keep the in-flight response.
//     fetch_pc<=br_target.
//   - DS not yet requested: clear queue, fetch_pc<=DS, save br_target, state WAIT_DS.
//  WAIT_DS -> RUN when DS is issued; next issue uses the saved br_target. A further br_taken in WAIT_DS is ignored
//  (ID cannot issue one before DS).
//  Issue is still permitted in the br_taken cycle. It uses the post-redirect address, selected combinationally.
//  Reset asserted mid-operation discards everything; the first request after release is RESET_PC.
// CONFIGURATION
//  IFQ_PERF_CNT_EN defined: adds out ports perf_empty_cyc[31:0] and perf_flush_cnt[31:0].
//   - perf_empty_cyc counts cycles with count==0; perf_flush_cnt counts br_taken pulses.
//   - Both reset to 0 and wrap.
//  Not defined: ports and counters are absent; function is otherwise identical.
// STRUCTURE
//  Shared header mycpu.h: IFQ_ENTRY_WD (=PC_W+INST_W) and RESET_PC. It also defines the FS-to-DS bus width, which must
//  equal IFQ_ENTRY_WD.
//  Sub-module ifq_fifo: circular buffer with head/tail pointers wrapping at DEPTH and synchronous clear.
//  ifq_fifo also provides keep-head-only truncate.
//  Top level holds fetch_pc, the in-flight tracker, the RUN/WAIT_DS FSM and the issue logic.
// TESTING
//  1 Reset release, ds_allowin=1, SRAM returns addr as data -> addrs bfc00000,..04,..08 in consecutive cycles.
//    ID receives the same pcs in order, first one 2 cycles after first request.
//  2 ds_allowin=0 for 10 cycles (DEPTH=4) -> exactly 4 requests issued, ifq_count=4, inst_sram_en=0 until pop.
//    Then 1 pop -> exactly 1 new request.
//  3 br_taken br_pc=bfc00000 target=bfc00100 while queue holds ..04,..08,..0c -> only ..04 survives.
//    Next request bfc00100. ID sees ..04 then ..100.
//  4 br_taken with DS in flight -> queue emptied, DS delivered, next pc = target, no stale pc reaches ID.
//  5 br_taken with DS unrequested -> WAIT_DS; requests DS then target back-to-back. ID sees DS, target.
//  6 Assert resetn=0 mid-stream, then release -> queue empty, first request bfc00000.
//    With IFQ_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/if_prefetch_queue_pkg.sv
// Shared fetch-stage definitions: entry width, reset PC and the redirect FSM encoding.
package if_prefetch_queue_pkg;

  localparam int unsigned IFQ_PC_W     = 32;
  localparam int unsigned IFQ_INST_W   = 32;
  localparam int unsigned IFQ_ENTRY_WD = IFQ_PC_W + IFQ_INST_W;
  localparam int unsigned FS_TO_DS_WD  = IFQ_ENTRY_WD;
  localparam logic [31:0] IFQ_RESET_PC = 32'hbfc0_0000;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_WAIT_DS = 1'b1
  } ifq_state_e;

endpackage

// File: rtl/if_prefetch_queue_fifo.sv
// Circular prefetch buffer with synchronous clear and keep-head-only truncate.
module ifq_fifo
  import if_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = IFQ_ENTRY_WD
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     clr,
  input  logic                     keep_head,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] wr_idx;
  logic [CNT_W-1:0] kept;
  logic [CNT_W-1:0] count_n;
  logic             popped;

  // Flush/truncate first, then pop, then append behind what survived.
  always_comb begin
    kept = count;
    if (keep_head) begin
      kept = (count != '0) ? CNT_W'(1) : '0;
    end else if (clr) begin
      kept = '0;
    end
    popped  = pop && (kept != '0);
    wr_idx  = head + kept[PTR_W-1:0];
    count_n = kept - CNT_W'(popped) + CNT_W'(push);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(popped);
      count <= count_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= push_data;
  end

  assign head_data = mem[head];

endmodule

// File: rtl/if_prefetch_queue.sv
// Fetch stage with prefetch queue, branch redirect and delay-slot preservation.
// Optional IFQ_PERF_CNT_EN adds empty-cycle and flush performance counters.
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(IFQ_RESET_PC)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     br_taken,
  input  logic [PC_W-1:0]          br_pc,
  input  logic [PC_W-1:0]          br_target,
  input  logic                     ds_allowin,
  output logic                     fs_to_ds_valid,
  output logic [PC_W+INST_W-1:0]   fs_to_ds_bus,
  output logic                     inst_sram_en,
  output logic [3:0]               inst_sram_wen,
  output logic [PC_W-1:0]          inst_sram_addr,
  output logic [31:0]              inst_sram_wdata,
  input  logic [INST_W-1:0]        inst_sram_rdata,
  output logic [$clog2(DEPTH):0]   ifq_count
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0]              perf_empty_cyc,
  output logic [31:0]              perf_flush_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam int unsigned ENT_W = PC_W + INST_W;

  ifq_state_e       state;
  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  req_pc;
  logic [PC_W-1:0]  saved_target;
  logic             inflight;

  logic [ENT_W-1:0] head_data;
  logic [CNT_W-1:0] count;
  logic [PC_W-1:0]  ds_pc;
  logic [PC_W-1:0]  head_pc;
  logic [PC_W-1:0]  issue_pc;
  logic [OCC_W-1:0] occ;
  logic             pop, br_eff, ds_in_q, ds_in_fl, ds_unreq;
  logic             issue, push, fifo_clr;

  // Classify the redirect by where the delay slot currently lives.
  always_comb begin
    pop      = fs_to_ds_valid & ds_allowin;
    ds_pc    = br_pc + PC_W'(4);
    head_pc  = head_data[PC_W-1:0];
    br_eff   = br_taken & (state == ST_RUN);
    ds_in_q  = br_eff & fs_to_ds_valid & (head_pc == ds_pc);
    ds_in_fl = br_eff & ~ds_in_q & inflight & (req_pc == ds_pc);
    ds_unreq = br_eff & ~ds_in_q & ~ds_in_fl;
    occ      = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
    issue    = resetn & (occ < OCC_W'(DEPTH));
    issue_pc = fetch_pc;
    if (ds_unreq) begin
      issue_pc = ds_pc;
    end else if (ds_in_q | ds_in_fl) begin
      issue_pc = br_target;
    end
    push     = inflight & ~(ds_in_q | ds_unreq);
    fifo_clr = ds_in_fl | ds_unreq;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_RUN;
      fetch_pc     <= RESET_PC;
      req_pc       <= RESET_PC;
      saved_target <= RESET_PC;
      inflight     <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) req_pc <= issue_pc;
      if (issue) begin
        if (ds_unreq) begin
          fetch_pc <= br_target;
          state    <= ST_RUN;
        end else if (state == ST_WAIT_DS) begin
          fetch_pc <= saved_target;
          state    <= ST_RUN;
        end else begin
          fetch_pc <= issue_pc + PC_W'(4);
        end
      end else if (ds_unreq) begin
        fetch_pc     <= ds_pc;
        saved_target <= br_target;
        state        <= ST_WAIT_DS;
      end else if (ds_in_q | ds_in_fl) begin
        fetch_pc <= br_target;
      end
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data ({inst_sram_rdata, req_pc}),
    .pop       (pop),
    .clr       (fifo_clr),
    .keep_head (ds_in_q),
    .head_data (head_data),
    .count     (count)
  );

  assign fs_to_ds_valid  = (count != '0);
  assign fs_to_ds_bus    = head_data;
  assign ifq_count       = count;
  assign inst_sram_en    = issue;
  assign inst_sram_addr  = issue_pc;
  assign inst_sram_wen   = 4'h0;
  assign inst_sram_wdata = 32'h0;

`ifdef IFQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_empty_cyc <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (count == '0) perf_empty_cyc <= perf_empty_cyc + 32'd1;
      if (br_taken)    perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
